flash_read_burst: RTL and testbench
===================================

Name: flash_read_burst

Overview:
- Parametrised SPI-NOR flash read controller; successor to the fixed-length single-command flash reader.
- Issues READ DATA (0x03, or FAST READ 0x0B with one dummy byte), READ ID (0x9F) or READ STATUS (0x05) through the byte-level spi_master handshake.
- READ DATA length is programmable per request. Every received payload byte is streamed out as a tagged byte with valid and last markers, for the display/UART path.

Parameters:
- ADDR_BYTES, 3, address bytes sent after the READ opcode (3 or 4).
- MAX_LEN, 256, maximum READ DATA payload bytes per request.
- LEN_W, 9, width of rd_len; must satisfy 2^LEN_W > MAX_LEN.
- ID_BYTES, 3, payload bytes returned by READ ID.
- FAST_READ, 0, 1 selects opcode 0x0B plus one 0x00 dummy byte after the address.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rd_id  in  1  single-cycle READ ID request
- rd_status  in  1  single-cycle READ STATUS request
- rd_data  in  1  single-cycle READ DATA request
- rd_addr  in  8*ADDR_BYTES  start address, sampled on accept
- rd_len  in  LEN_W  payload byte count, sampled on accept
- busy  out  1  high from the accept edge until the return to IDLE
- trans_req  out  1  to spi_master: held high for the whole transaction
- tx_dout  out  8  to spi_master: byte to transmit
- rx_din  in  8  from spi_master: byte received
- trans_done  in  1  from spi_master: one byte exchanged, rx_din valid
- dout  out  8  payload byte
- dout_tag  out  2  payload source: 0 data, 1 id, 2 status
- dout_vld  out  1  dout valid, one cycle per byte
- dout_last  out  1  with dout_vld, final byte of the transaction
- done  out  1  one-cycle pulse at end of transaction
- err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset values: state IDLE. busy, trans_req, dout_vld, dout_last, done and err are 0. tx_dout, dout and dout_tag are 0. All counters are 0.
- States are IDLE, HDR, PAYLD and DONE.
- IDLE accepts a request when it sees one. Priority is rd_id > rd_status > rd_data; losing requests in the same cycle are dropped.
- Requests arriving outside IDLE are ignored silently.
- rd_data with rd_len==0 or rd_len>MAX_LEN is rejected: err=1 for one cycle, state stays IDLE.
- On accept at edge T:
  - latch mode, rd_addr and rd_len;
  - state goes to HDR;
  - trans_req, busy and tx_dout=opcode are all valid from T+1.
- Header length: 1 byte for ID and STATUS; 1+ADDR_BYTES+FAST_READ bytes for DATA.
- Header byte order: opcode, address MSB first, then the dummy byte if FAST_READ.
- HDR state:
  - Each trans_done increments the byte counter and loads the next header byte into tx_dout on the same edge.
  - The trans_done of the last header byte moves the state to PAYLD and sets tx_dout=0x00.
  - rx_din is discarded throughout HDR.
- PAYLD length: ID_BYTES for ID, 1 for STATUS, the latched rd_len for DATA.
- PAYLD state:
  - Each trans_done registers dout<=rx_din and sets dout_tag; dout_vld is high for exactly the next cycle.
  - tx_dout stays 0x00 throughout PAYLD.
  - On the last payload trans_done: dout_last=1 with that byte's dout_vld, trans_req drops on the same edge, state goes to DONE.
- DONE lasts one cycle: done=1, then state returns to IDLE and busy drops. A new request is accepted in the first IDLE cycle.
- Latency from a trans_done to the matching dout_vld is 1 cycle.
- trans_done in IDLE or DONE is ignored.
- The payload counter is LEN_W bits and never wraps within a transaction. Address wrap-around inside the flash is the flash's own behaviour; this block does not modify it.
- Reset asserted mid-transaction: trans_req drops immediately, no dout_vld and no done are emitted, state is IDLE after release.
- dout holds its last value between valid pulses.

Test Plan:
- READ ID, flash returns 20 20 15 → tx_dout 9F,00,00,00 over 4 trans_done; dout 20,20,15 with tag 1; dout_last on 15; done 1 cycle after; trans_req falls with the 4th trans_done.
- READ DATA, addr 0x012345, len 4, rx AA BB CC DD → tx 03,01,23,45,00×4; 4 dout_vld with tag 0; dout_last on DD; 8 trans_done in total.
- FAST_READ=1, ADDR_BYTES=4, addr 0x00ABCDEF, len 1 → tx 0B,00,AB,CD,EF,00 (dummy),00; exactly one dout_vld.
- rd_id, rd_status and rd_data asserted in the same cycle → READ ID executed only; rd_data pulsed while busy → ignored, no err.
- rd_data with len 0, then with len MAX_LEN+1 → err pulse each time, trans_req stays 0; len MAX_LEN → MAX_LEN dout_vld, last marked.
- rst_n asserted after the 2nd payload byte of a len-8 read → all outputs 0 asynchronously; a READ STATUS after release returns the status byte with tag 2 and dout_last=1.

Source files
------------

// File: rtl/flash_read_burst.sv
// SPI-NOR read controller: READ DATA (0x03 / 0x0B + dummy), READ ID and READ STATUS over
// the byte-level spi_master handshake; payload bytes stream out tagged with valid/last.
module flash_read_burst #(
  parameter int ADDR_BYTES = 3,
  parameter int MAX_LEN    = 256,
  parameter int LEN_W      = 9,
  parameter int ID_BYTES   = 3,
  parameter int FAST_READ  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_id,
  input  logic                    rd_status,
  input  logic                    rd_data,
  input  logic [8*ADDR_BYTES-1:0] rd_addr,
  input  logic [LEN_W-1:0]        rd_len,
  output logic                    busy,
  output logic                    trans_req,
  output logic [7:0]              tx_dout,
  input  logic [7:0]              rx_din,
  input  logic                    trans_done,
  output logic [7:0]              dout,
  output logic [1:0]              dout_tag,
  output logic                    dout_vld,
  output logic                    dout_last,
  output logic                    done,
  output logic                    err
);

  localparam int AW       = 8 * ADDR_BYTES;
  localparam int HDR_DATA = 1 + ADDR_BYTES + FAST_READ;

  localparam logic [1:0] TAG_DATA = 2'd0;
  localparam logic [1:0] TAG_ID   = 2'd1;
  localparam logic [1:0] TAG_STAT = 2'd2;

  typedef enum logic [1:0] {IDLE, HDR, PAYLD, DONE} state_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [AW-1:0]    addr;
    logic [LEN_W-1:0] len;
  } req_t;

  state_t           state_q, state_d;
  req_t             req_q, req_d;
  logic [2:0]       hdr_cnt_q, hdr_cnt_d;
  logic [LEN_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       dout_q, dout_d;
  logic [1:0]       tag_q, tag_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             err_q, err_d;

  function automatic logic [7:0] opcode(input logic [1:0] mode);
    case (mode)
      TAG_ID:   return 8'h9F;
      TAG_STAT: return 8'h05;
      default:  return (FAST_READ != 0) ? 8'h0B : 8'h03;
    endcase
  endfunction

  // Byte idx of the header: opcode, address MSB first, then the dummy byte.
  function automatic logic [7:0] hdr_byte(input req_t r, input logic [2:0] idx);
    logic [AW-1:0] sh;
    sh = '0;
    if (idx == 3'd0) return opcode(r.mode);
    if (int'(idx) <= ADDR_BYTES) begin
      sh = r.addr >> (8 * (ADDR_BYTES - int'(idx)));
      return sh[7:0];
    end
    return 8'h00;
  endfunction

  function automatic logic [2:0] hdr_len(input logic [1:0] mode);
    return (mode == TAG_DATA) ? 3'(HDR_DATA) : 3'd1;
  endfunction

  function automatic logic [LEN_W-1:0] pay_len(input req_t r);
    case (r.mode)
      TAG_ID:   return LEN_W'(ID_BYTES);
      TAG_STAT: return LEN_W'(1);
      default:  return r.len;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      hdr_cnt_q <= '0;
      pay_cnt_q <= '0;
      tx_q      <= '0;
      dout_q    <= '0;
      tag_q     <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      tx_q      <= tx_d;
      dout_q    <= dout_d;
      tag_q     <= tag_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    req_t acc;
    logic go;
    state_d   = state_q;
    req_d     = req_q;
    hdr_cnt_d = hdr_cnt_q;
    pay_cnt_d = pay_cnt_q;
    tx_d      = tx_q;
    dout_d    = dout_q;
    tag_d     = tag_q;
    vld_d     = 1'b0;
    last_d    = 1'b0;
    err_d     = 1'b0;
    acc       = '{mode: TAG_DATA, addr: rd_addr, len: rd_len};
    go        = 1'b0;
    case (state_q)
      IDLE: begin
        // Fixed priority; requests that lose in the same cycle are dropped.
        if (rd_id) begin
          acc.mode = TAG_ID;
          go       = 1'b1;
        end else if (rd_status) begin
          acc.mode = TAG_STAT;
          go       = 1'b1;
        end else if (rd_data) begin
          if (rd_len != '0 && rd_len <= LEN_W'(MAX_LEN)) go = 1'b1;
          else                                          err_d = 1'b1;
        end
        if (go) begin
          req_d     = acc;
          state_d   = HDR;
          hdr_cnt_d = '0;
          pay_cnt_d = '0;
          tx_d      = opcode(acc.mode);
        end
      end
      HDR: begin
        if (trans_done) begin
          if (hdr_cnt_q + 3'd1 == hdr_len(req_q.mode)) begin
            state_d   = PAYLD;
            hdr_cnt_d = '0;
            tx_d      = 8'h00;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
            tx_d      = hdr_byte(req_q, hdr_cnt_q + 3'd1);
          end
        end
      end
      PAYLD: begin
        if (trans_done) begin
          dout_d    = rx_din;
          tag_d     = req_q.mode;
          vld_d     = 1'b1;
          pay_cnt_d = pay_cnt_q + LEN_W'(1);
          if (pay_cnt_q + LEN_W'(1) == pay_len(req_q)) begin
            last_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake/status outputs follow the registered state so reset clears them at once.
  assign busy      = (state_q != IDLE);
  assign trans_req = (state_q == HDR) || (state_q == PAYLD);
  assign done      = (state_q == DONE);
  assign tx_dout   = tx_q;
  assign dout      = dout_q;
  assign dout_tag  = tag_q;
  assign dout_vld  = vld_q;
  assign dout_last = last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_flash_read_burst.sv
// Randomized bench for flash_read_burst: two configurations (3-byte normal read and
// 4-byte fast read), a byte-level SPI responder and a queue-based expected-frame model.
module tb_flash_read_burst;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rd_id = '0, rd_status = '0, rd_data = '0, trans_done = '0;
  logic [1:0][7:0] rx_din = '0;
  logic [23:0]     addr0 = '0;
  logic [31:0]     addr1 = '0;
  logic [8:0]      len0 = '0;
  logic [4:0]      len1 = '0;

  wire [1:0]      busy, trans_req, dout_vld, dout_last, done, err;
  wire [1:0][7:0] tx_dout, dout;
  wire [1:0][1:0] dout_tag;

  flash_read_burst u_dut0 (
    .clk(clk), .rst_n(rst_n), .rd_id(rd_id[0]), .rd_status(rd_status[0]), .rd_data(rd_data[0]),
    .rd_addr(addr0), .rd_len(len0), .busy(busy[0]), .trans_req(trans_req[0]), .tx_dout(tx_dout[0]),
    .rx_din(rx_din[0]), .trans_done(trans_done[0]), .dout(dout[0]), .dout_tag(dout_tag[0]),
    .dout_vld(dout_vld[0]), .dout_last(dout_last[0]), .done(done[0]), .err(err[0]));

  flash_read_burst #(.ADDR_BYTES(4), .MAX_LEN(16), .LEN_W(5), .FAST_READ(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rd_id(rd_id[1]), .rd_status(rd_status[1]), .rd_data(rd_data[1]),
    .rd_addr(addr1), .rd_len(len1), .busy(busy[1]), .trans_req(trans_req[1]), .tx_dout(tx_dout[1]),
    .rx_din(rx_din[1]), .trans_done(trans_done[1]), .dout(dout[1]), .dout_tag(dout_tag[1]),
    .dout_vld(dout_vld[1]), .dout_last(dout_last[1]), .done(done[1]), .err(err[1]));

  int n_cmp = 0, n_bad = 0;
  int vcnt[2], dcnt[2], ecnt[2];

  // Pulse counters sampled mid-cycle.
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      if (dout_vld[i]) vcnt[i] <= vcnt[i] + 1;
      if (done[i])     dcnt[i] <= dcnt[i] + 1;
      if (err[i])      ecnt[i] <= ecnt[i] + 1;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int ab(input int d);   return d ? 4 : 3;    endfunction
  function automatic int maxl(input int d); return d ? 16 : 256; endfunction

  task automatic set_req(input int d, input logic [31:0] a, input int l);
    if (d == 0) begin addr0 = a[23:0]; len0 = 9'(l); end
    else        begin addr1 = a;       len1 = 5'(l); end
  endtask

  function automatic logic [23:0] outs(input int d);
    return {trans_req[d], busy[d], dout_vld[d], dout_last[d], done[d], err[d],
            tx_dout[d], dout[d], dout_tag[d]};
  endfunction

  // kind: 0 data, 1 id, 2 status. abort_at>=0 resets after that many payload bytes.
  task automatic run(input int d, input int kind, input logic [31:0] addr, input int len,
                     input logic [2:0] mask, input int abort_at, input bit poke);
    logic [7:0] exp_tx[$];
    logic [7:0] pay[$];
    int hdr, plen, tot, n, got_pay, v0, d0, e0;
    plen = (kind == 1) ? 3 : (kind == 2) ? 1 : len;
    exp_tx.push_back(kind == 1 ? 8'h9F : kind == 2 ? 8'h05 : (d ? 8'h0B : 8'h03));
    if (kind == 0) begin
      for (int i = ab(d) - 1; i >= 0; i--) exp_tx.push_back(8'(addr >> (8 * i)));
      if (d) exp_tx.push_back(8'h00);
    end
    hdr = exp_tx.size();
    for (int i = 0; i < plen; i++) begin
      exp_tx.push_back(8'h00);
      pay.push_back(8'($urandom));
    end
    tot = hdr + plen;
    v0 = vcnt[d]; d0 = dcnt[d]; e0 = ecnt[d];
    set_req(d, addr, len);
    rd_id[d] = mask[2]; rd_status[d] = mask[1]; rd_data[d] = mask[0];
    tick;
    rd_id[d] = 1'b0; rd_status[d] = 1'b0; rd_data[d] = 1'b0;
    chk("busy_acc", busy[d], 1);
    n = 0; got_pay = 0;
    while (trans_req[d] && n < tot + 4) begin
      if (abort_at >= 0 && got_pay == abort_at) break;
      repeat ($urandom_range(0, 2)) tick;
      if (poke && n == 1) begin
        set_req(d, 0, 0); rd_data[d] = 1'b1; tick; rd_data[d] = 1'b0;
      end
      chk($sformatf("tx%0d", n), tx_dout[d], n < tot ? exp_tx[n] : 8'h00);
      rx_din[d] = (n >= hdr && n < tot) ? pay[n - hdr] : 8'($urandom);
      trans_done[d] = 1'b1;
      tick;
      trans_done[d] = 1'b0;
      if (n >= hdr && n < tot) begin
        chk("vld", dout_vld[d], 1);
        chk("dout", dout[d], pay[n - hdr]);
        chk("tag", dout_tag[d], kind);
        chk("last", dout_last[d], n == tot - 1);
        got_pay++;
      end else
        chk("vld_hdr", dout_vld[d], 0);
      chk("treq", trans_req[d], n < tot - 1);
      n++;
    end
    if (abort_at >= 0) begin
      tick;
      rst_n = 1'b0;
      #1;
      chk("rst_outs", outs(d), 0);
      tick; tick;
      rst_n = 1'b1;
      tick;
      chk("busy_rst", busy[d], 0);
      chk("vld_cnt_rst", vcnt[d] - v0, abort_at);
      chk("done_cnt_rst", dcnt[d] - d0, 0);
    end else begin
      chk("n_bytes", n, tot);
      chk("done", done[d], 1);
      chk("busy_done", busy[d], 1);
      tick;
      chk("done_end", done[d], 0);
      chk("busy_end", busy[d], 0);
      chk("tx_idle", tx_dout[d], 0);
      chk("vld_cnt", vcnt[d] - v0, plen);
      chk("done_cnt", dcnt[d] - d0, 1);
      chk("err_cnt", ecnt[d] - e0, 0);
    end
  endtask

  task automatic bad_len(input int d, input int len);
    int e0;
    e0 = ecnt[d];
    set_req(d, $urandom, len);
    rd_data[d] = 1'b1;
    tick;
    rd_data[d] = 1'b0;
    chk("err", err[d], 1);
    chk("treq_err", trans_req[d], 0);
    chk("busy_err", busy[d], 0);
    tick;
    chk("err_end", err[d], 0);
    chk("err_cnt1", ecnt[d] - e0, 1);
  endtask

  initial begin
    int d, kind;
    logic [2:0] mask;
    repeat (3) tick;
    chk("reset0", outs(0), 0);
    chk("reset1", outs(1), 0);
    rst_n = 1'b1;
    tick;

    run(0, 1, 0, 0, 3'b111, -1, 0);                 // ID wins over status and data
    run(0, 0, 32'h0001_2345, 4, 3'b001, -1, 1);     // data, rd_data poked while busy
    run(1, 0, 32'h00AB_CDEF, 1, 3'b001, -1, 0);     // fast read, 4-byte address
    bad_len(0, 0);
    bad_len(0, 257);
    bad_len(1, 0);
    bad_len(1, 17);
    run(0, 0, $urandom, 256, 3'b001, -1, 0);
    run(1, 0, $urandom, 16, 3'b001, -1, 0);
    run(0, 0, $urandom, 8, 3'b001, 2, 0);           // reset after 2nd payload byte
    run(0, 2, 0, 0, 3'b010, -1, 0);
    run(1, 1, 0, 0, 3'b100, -1, 0);

    for (int t = 0; t < 24; t++) begin
      d    = $urandom_range(0, 1);
      kind = $urandom_range(0, 2);
      mask = (kind == 1) ? {1'b1, 2'($urandom)} :
             (kind == 2) ? {2'b01, 1'($urandom)} : 3'b001;
      run(d, kind, $urandom, $urandom_range(1, d ? 16 : 24), mask, -1, $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
